// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage multicycle ALU and its issue controller.
package alu_pkg;

   localparam logic [3:0] FU_OP_ADD  = 4'h0;
   localparam logic [3:0] FU_OP_MULT = 4'h1;
   localparam logic [3:0] FU_OP_NOP  = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } issue_state_t;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issues one multicycle op at a time to the ALU, stalls the pipe until the
// result (or a timeout) arrives, then presents a one-cycle writeback beat.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic        ex_multicycle,
   input  logic [3:0]  ex_op,
   input  logic [31:0] ex_a,
   input  logic [31:0] ex_b,
   input  logic [4:0]  ex_rd,
   input  logic        flush,
   output logic [3:0]  fu_op,
   output logic [31:0] fu_a,
   output logic [31:0] fu_b,
   input  logic        fu_busy,
   input  logic        fu_done,
   input  logic [31:0] fu_result,
   output logic        stall,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_err
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   issue_state_t     state, state_nxt;
   logic [3:0]       op_q;
   logic [4:0]       rd_q;
   logic [CNT_W-1:0] wait_cnt;
   logic             squashed;
   logic             err_q;
   logic             accept;
   logic             fin;
   logic             timeout;

   assign accept  = (state == ST_IDLE) & ex_valid & ex_multicycle & ~flush;
   // fu_done is level-style and may be stale from the last op, so it only counts in WAIT.
   assign fin     = (state == ST_WAIT) & fu_done & ~fu_busy;
   assign timeout = (state == ST_WAIT) & ~fin & (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
   assign wb_rd   = rd_q;
   assign wb_err  = wb_valid & err_q;

   always_comb begin
      // NOTE: every output gets a default before the case so no latch is inferred.
      state_nxt = state;
      fu_op     = FU_OP_NOP;
      stall     = 1'b0;
      wb_valid  = 1'b0;
      case (state)
         ST_IDLE: begin
            stall = accept;
            if (accept) state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            fu_op     = op_q;
            stall     = 1'b1;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            // Dropping to NOP on fin keeps the ALU from restarting a MULT.
            fu_op = fin ? FU_OP_NOP : op_q;
            stall = 1'b1;
            if (fin || timeout) state_nxt = ST_RESP;
         end
         ST_RESP: begin
            wb_valid  = ~squashed & ~flush;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         op_q     <= FU_OP_NOP;
         fu_a     <= '0;
         fu_b     <= '0;
         rd_q     <= '0;
         wb_data  <= '0;
         wait_cnt <= '0;
         squashed <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q     <= ex_op;
                  fu_a     <= ex_a;
                  fu_b     <= ex_b;
                  rd_q     <= ex_rd;
                  squashed <= 1'b0;
                  err_q    <= 1'b0;
               end
            end
            ST_ISSUE: begin
               wait_cnt <= '0;
               if (flush) squashed <= 1'b1;
            end
            ST_WAIT: begin
               // A squashed op still drains the ALU before returning to IDLE.
               if (flush) squashed <= 1'b1;
               if (fin) begin
                  wb_data <= fu_result;
               end else if (timeout) begin
                  err_q   <= 1'b1;
                  wb_data <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a cycle-accurate ALU model, a
// per-cycle transaction model of the controller, and directed scenarios.
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid, ex_multicycle, flush;
   logic [3:0]  ex_op;
   logic [31:0] ex_a, ex_b;
   logic [4:0]  ex_rd;
   logic [3:0]  fu_op;
   logic [31:0] fu_a, fu_b;
   logic        fu_busy, fu_done;
   logic [31:0] fu_result;
   logic        stall, wb_valid, wb_err;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .ex_valid(ex_valid), .ex_multicycle(ex_multicycle), .ex_op(ex_op),
      .ex_a(ex_a), .ex_b(ex_b), .ex_rd(ex_rd), .flush(flush),
      .fu_op(fu_op), .fu_a(fu_a), .fu_b(fu_b),
      .fu_busy(fu_busy), .fu_done(fu_done), .fu_result(fu_result),
      .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_err(wb_err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ALU model: ADD completes in one cycle, MULT is busy four cycles; done is a held level.
   logic hang = 1'b0;
   int   mk = 0;
   int   busy_starts = 0;
   always @(posedge clk) begin
      if (reset) begin
         fu_busy <= 1'b0; fu_done <= 1'b0; fu_result <= '0; mk <= 0;
      end else if (hang) begin
         fu_busy <= 1'b1; fu_done <= 1'b0; mk <= 0;
      end else if (fu_busy) begin
         if (mk == 0) begin
            fu_busy <= 1'b0; fu_done <= 1'b1; fu_result <= fu_a * fu_b;
         end else mk <= mk - 1;
      end else if (fu_op == FU_OP_ADD) begin
         fu_done <= 1'b1; fu_result <= fu_a + fu_b;
      end else if (fu_op == FU_OP_MULT) begin
         fu_busy <= 1'b1; fu_done <= 1'b0; mk <= 3; busy_starts <= busy_starts + 1;
      end
   end

   // Transaction model state and monitor records.
   logic        m_flight = 1'b0, m_resp = 1'b0, m_sq = 1'b0, m_err = 1'b0;
   int          m_acc = 0;
   logic [3:0]  m_op = FU_OP_NOP;
   logic [31:0] m_a = '0, m_b = '0, m_data = '0;
   logic [4:0]  m_rd = '0;

   int          stall_cnt = 0, n_wb = 0, last_wb_cyc = 0;
   logic [31:0] last_wb_data = '0;
   logic [4:0]  last_wb_rd = '0;
   logic        last_wb_err = 1'b0, last_wb_stall = 1'b0;
   logic [3:0]  op_hist [0:1023];

   always @(negedge clk) begin : compare
      logic [3:0] e_op;
      logic       e_stall, e_wbv, e_err, e_acc, e_fin;
      int         age;
      if (reset) begin
         m_flight = 1'b0; m_resp = 1'b0; m_sq = 1'b0; m_err = 1'b0;
         m_a = '0; m_b = '0; m_data = '0; m_rd = '0;
      end else begin
         e_op = FU_OP_NOP; e_stall = 1'b0; e_wbv = 1'b0; e_err = 1'b0;
         e_acc = 1'b0; e_fin = 1'b0; age = cyc - m_acc;
         if (m_resp) begin
            e_wbv = !m_sq && !flush;
            e_err = e_wbv && m_err;
         end else if (m_flight) begin
            e_stall = 1'b1;
            e_fin   = (age >= 2) && fu_done && !fu_busy;
            e_op    = e_fin ? FU_OP_NOP : m_op;
         end else begin
            e_acc   = ex_valid && ex_multicycle && !flush;
            e_stall = e_acc;
         end

         check("fu_op",    32'(fu_op),    32'(e_op));
         check("stall",    32'(stall),    32'(e_stall));
         check("wb_valid", 32'(wb_valid), 32'(e_wbv));
         check("wb_err",   32'(wb_err),   32'(e_err));
         check("fu_a",     fu_a,          m_a);
         check("fu_b",     fu_b,          m_b);
         check("wb_data",  wb_data,       m_data);
         if (e_wbv) check("wb_rd", 32'(wb_rd), 32'(m_rd));

         if (stall) stall_cnt++;
         if (wb_valid) begin
            n_wb++; last_wb_cyc = cyc; last_wb_data = wb_data;
            last_wb_rd = wb_rd; last_wb_err = wb_err; last_wb_stall = stall;
         end
         op_hist[cyc % 1024] = fu_op;

         if (m_resp) m_resp = 1'b0;
         else if (m_flight) begin
            if (flush) m_sq = 1'b1;
            if (e_fin) begin
               m_data = fu_result; m_err = 1'b0; m_flight = 1'b0; m_resp = 1'b1;
            end else if (age >= 2 && age - 2 == TO) begin
               m_data = '0; m_err = 1'b1; m_flight = 1'b0; m_resp = 1'b1;
            end
         end else if (e_acc) begin
            m_flight = 1'b1; m_acc = cyc; m_sq = 1'b0;
            m_op = ex_op; m_a = ex_a; m_b = ex_b; m_rd = ex_rd;
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      stall_cnt = 0; n_wb = 0; busy_starts = 0;
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int acc);
      next_cycle();
      ex_valid = 1'b1; ex_multicycle = 1'b1; ex_op = op; ex_a = a; ex_b = b; ex_rd = rd;
      acc = cyc;
      next_cycle();
      ex_valid = 1'b0; ex_multicycle = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int acc, acc2;
      reset = 1'b1; ex_valid = 1'b0; ex_multicycle = 1'b0; flush = 1'b0;
      ex_op = FU_OP_NOP; ex_a = '0; ex_b = '0; ex_rd = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset fu_op",    32'(fu_op), 32'(FU_OP_NOP));
      check("reset stall",    32'(stall), 0);
      check("reset wb_valid", 32'(wb_valid), 0);
      check("reset wb_rd",    32'(wb_rd), 0);
      check("reset wb_data",  wb_data, 0);

      // ADD 5+7 -> rd 3
      clear_mon();
      run_op(FU_OP_ADD, 32'd5, 32'd7, 5'd3, acc);
      repeat (6) next_cycle();
      check("add n_wb",     32'(n_wb), 1);
      check("add latency",  32'(last_wb_cyc - acc), 3);
      check("add data",     last_wb_data, 12);
      check("add rd",       32'(last_wb_rd), 3);
      check("add stalls",   32'(stall_cnt), 3);
      check("add op c1",    32'(op_hist[(acc + 1) % 1024]), 32'(FU_OP_ADD));
      check("add op c2",    32'(op_hist[(acc + 2) % 1024]), 32'(FU_OP_NOP));

      // MULT 300*7 -> rd 9
      clear_mon();
      run_op(FU_OP_MULT, 32'd300, 32'd7, 5'd9, acc);
      repeat (10) next_cycle();
      check("mul latency",  32'(last_wb_cyc - acc), 7);
      check("mul data",     last_wb_data, 2100);
      check("mul rd",       32'(last_wb_rd), 9);
      check("mul stalls",   32'(stall_cnt), 7);
      check("mul op c6",    32'(op_hist[(acc + 6) % 1024]), 32'(FU_OP_NOP));
      check("mul starts",   32'(busy_starts), 1);

      // Back-to-back: MULT then ADD accepted the cycle after RESP (stale done in ISSUE)
      clear_mon();
      run_op(FU_OP_MULT, 32'd300, 32'd7, 5'd9, acc);
      repeat (6) next_cycle();
      run_op(FU_OP_ADD, 32'd1, 32'd1, 5'd4, acc2);
      repeat (6) next_cycle();
      check("b2b n_wb",     32'(n_wb), 2);
      check("b2b latency",  32'(last_wb_cyc - acc2), 3);
      check("b2b data",     last_wb_data, 2);
      check("b2b rd",       32'(last_wb_rd), 4);
      check("b2b stalls",   32'(stall_cnt), 10);
      check("b2b starts",   32'(busy_starts), 1);

      // Timeout: ALU held busy
      clear_mon();
      hang = 1'b1;
      run_op(FU_OP_MULT, 32'd3, 32'd4, 5'd6, acc);
      repeat (20) next_cycle();
      hang = 1'b0;
      repeat (4) next_cycle();
      check("to n_wb",      32'(n_wb), 1);
      check("to latency",   32'(last_wb_cyc - acc), 2 + TO + 1);
      check("to err",       32'(last_wb_err), 1);
      check("to data",      last_wb_data, 0);
      check("to stall",     32'(last_wb_stall), 0);
      check("to stalls",    32'(stall_cnt), 2 + TO + 1);

      // Flush in cycle 3 of a MULT, then a normal ADD
      clear_mon();
      run_op(FU_OP_MULT, 32'd300, 32'd7, 5'd9, acc);
      next_cycle();
      next_cycle();
      flush = 1'b1;
      next_cycle();
      flush = 1'b0;
      repeat (6) next_cycle();
      check("fl n_wb",      32'(n_wb), 0);
      check("fl stalls",    32'(stall_cnt), 7);
      clear_mon();
      run_op(FU_OP_ADD, 32'd20, 32'd22, 5'd1, acc);
      repeat (5) next_cycle();
      check("fl next n_wb", 32'(n_wb), 1);
      check("fl next data", last_wb_data, 42);
      check("fl next lat",  32'(last_wb_cyc - acc), 3);

      // Reset in cycle 4 of a MULT
      clear_mon();
      run_op(FU_OP_MULT, 32'd300, 32'd7, 5'd9, acc);
      repeat (3) next_cycle();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      check("rst fu_op",    32'(fu_op), 32'(FU_OP_NOP));
      check("rst stall",    32'(stall), 0);
      check("rst wb_valid", 32'(wb_valid), 0);
      check("rst wb_err",   32'(wb_err), 0);
      check("rst fu_a",     fu_a, 0);
      check("rst fu_b",     fu_b, 0);
      check("rst wb_rd",    32'(wb_rd), 0);
      check("rst wb_data",  wb_data, 0);
      repeat (10) next_cycle();
      check("rst n_wb",     32'(n_wb), 0);
      clear_mon();
      run_op(FU_OP_ADD, 32'd2, 32'd3, 5'd7, acc);
      repeat (5) next_cycle();
      check("rst next data", last_wb_data, 5);
      check("rst next rd",   32'(last_wb_rd), 7);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
